// File: rtl/refill_tracker_pkg.sv
// -----------------------------------------------------------------------------
// refill_tracker_pkg
// Shared types and helpers for the outstanding-refill tracker.
//   entry_t        : one tracker slot {valid, id, addr, age}. Fields are sized
//                    to the largest supported widths. Instances zero-extend
//                    their narrower values, and synthesis removes the constant
//                    upper bits.
//   lowest_set_idx : index of the lowest set bit, used for allocation and
//                    for the timeout index.
//   onehot_to_bin  : converts a one-hot match vector to an index.
// Supported limits: DEPTH <= 32, ID_WIDTH <= 32, ADDR_WIDTH <= 64,
// TO_WIDTH <= 16.
// -----------------------------------------------------------------------------
package refill_tracker_pkg;

    localparam int ID_W_MAX   = 32;
    localparam int ADDR_W_MAX = 64;
    localparam int AGE_W_MAX  = 16;
    localparam int VEC_W_MAX  = 32;
    localparam int IDX_W_MAX  = 5;

    typedef struct packed {
        logic                  valid;
        logic [ID_W_MAX-1:0]   id;
        logic [ADDR_W_MAX-1:0] addr;
        logic [AGE_W_MAX-1:0]  age;
    } entry_t;

    // The loop scans downward so that the last hit, which is the lowest
    // index, is the one that is returned.
    function automatic logic [IDX_W_MAX-1:0] lowest_set_idx(input logic [VEC_W_MAX-1:0] vec);
        logic [IDX_W_MAX-1:0] idx;
        idx = '0;
        for (int i = VEC_W_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W_MAX'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W_MAX-1:0] onehot_to_bin(input logic [VEC_W_MAX-1:0] oh);
        logic [IDX_W_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < VEC_W_MAX; i++) begin
            if (oh[i]) idx = idx | IDX_W_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/refill_tracker_if.sv
// -----------------------------------------------------------------------------
// refill_tracker_if
// Bundles the miss-handler and AXI-side signals of the refill tracker.
//   master : miss handler / R-channel side (drives push, pop, check, lookup, clear)
//   slave  : the tracker (drives full/empty/error, hit, valid, count, timeout)
// -----------------------------------------------------------------------------
interface refill_tracker_if #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 14,
    parameter int ADDR_WIDTH = 28
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic                  push_i;
    logic [ID_WIDTH-1:0]   push_ID_i;
    logic [ADDR_WIDTH-1:0] push_addr_i;
    logic                  push_full_o;
    logic                  push_error_o;
    logic                  pop_i;
    logic [ID_WIDTH-1:0]   pop_ID_i;
    logic                  pop_empty_o;
    logic                  pop_error_o;
    logic                  RESP_check_req_i;
    logic [ID_WIDTH-1:0]   RESP_check_ID_i;
    logic                  RESP_check_is_valid_o;
    logic [ADDR_WIDTH-1:0] lookup_addr_i;
    logic                  lookup_hit_o;
    logic [CNT_W-1:0]      count_o;
    logic                  timeout_o;
    logic [IDX_W-1:0]      timeout_idx_o;
    logic                  timeout_clr_i;

    modport master (
        output push_i, push_ID_i, push_addr_i, pop_i, pop_ID_i,
               RESP_check_req_i, RESP_check_ID_i, lookup_addr_i, timeout_clr_i,
        input  push_full_o, push_error_o, pop_empty_o, pop_error_o,
               RESP_check_is_valid_o, lookup_hit_o, count_o, timeout_o, timeout_idx_o
    );

    modport slave (
        input  push_i, push_ID_i, push_addr_i, pop_i, pop_ID_i,
               RESP_check_req_i, RESP_check_ID_i, lookup_addr_i, timeout_clr_i,
        output push_full_o, push_error_o, pop_empty_o, pop_error_o,
               RESP_check_is_valid_o, lookup_hit_o, count_o, timeout_o, timeout_idx_o
    );
endinterface

// File: rtl/refill_tracker_alloc.sv
// -----------------------------------------------------------------------------
// refill_tracker_alloc
// First-free priority encoder. It picks the lowest-index entry whose valid
// bit is clear.
//   valid_i       : current valid bits of the table
//   alloc_oh_o    : one-hot of the chosen free entry (all zero when full)
//   alloc_valid_o : at least one entry is free
// -----------------------------------------------------------------------------
module refill_tracker_alloc
    import refill_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] valid_i,
    output logic [DEPTH-1:0] alloc_oh_o,
    output logic             alloc_valid_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] free_vec;
    logic [IDX_W-1:0] free_idx;

    assign free_vec      = ~valid_i;
    assign alloc_valid_o = |free_vec;
    assign free_idx      = IDX_W'(lowest_set_idx(VEC_W_MAX'(free_vec)));

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        alloc_oh_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_valid_o && (free_idx == IDX_W'(i))) alloc_oh_o[i] = 1'b1;
        end
    end
endmodule

// File: rtl/refill_tracker_param.sv
// -----------------------------------------------------------------------------
// refill_tracker_param
// Outstanding-refill tracker for the L1.5 instruction cache. It records each
// AXI refill in flight by ID and line address, retires entries on the
// response, flags address hits so that misses to the same line merge, and
// runs a per-entry age watchdog.
//   clk, rst_n : clock; asynchronous active-low reset
//   bus        : refill_tracker_if slave modport. It carries push/pop with
//                their full/empty/error flags, the response-ID check, the
//                line lookup, count_o, and the sticky timeout with its index
//                and clear.
// -----------------------------------------------------------------------------
module refill_tracker_param
    import refill_tracker_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 14,
    parameter int ADDR_WIDTH = 28,
    parameter int TO_WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    refill_tracker_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AGE_W_MAX-1:0] AGE_MAX = AGE_W_MAX'((64'd1 << TO_WIDTH) - 64'd1);

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] tidx_q, tidx_d;

    logic [DEPTH-1:0] valid_vec, push_match, pop_match, chk_match, look_match, at_max;
    logic [DEPTH-1:0] alloc_oh;
    logic             alloc_valid, push_accept, pop_do;
    logic [IDX_W-1:0] pop_idx;

    // Every compare reads the pre-edge table, so a same-cycle push is not visible.
    always_comb begin
        valid_vec  = '0;
        push_match = '0;
        pop_match  = '0;
        chk_match  = '0;
        look_match = '0;
        at_max     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i]  = entry_q[i].valid;
            push_match[i] = entry_q[i].valid && (entry_q[i].id   == ID_W_MAX'(bus.push_ID_i));
            pop_match[i]  = entry_q[i].valid && (entry_q[i].id   == ID_W_MAX'(bus.pop_ID_i));
            chk_match[i]  = entry_q[i].valid && (entry_q[i].id   == ID_W_MAX'(bus.RESP_check_ID_i));
            look_match[i] = entry_q[i].valid && (entry_q[i].addr == ADDR_W_MAX'(bus.lookup_addr_i));
            at_max[i]     = entry_q[i].valid && (entry_q[i].age  == AGE_MAX);
        end
    end

    refill_tracker_alloc #(.DEPTH(DEPTH)) u_alloc (
        .valid_i       (valid_vec),
        .alloc_oh_o    (alloc_oh),
        .alloc_valid_o (alloc_valid)
    );

    // A duplicate live ID rejects the push. This keeps IDs unique, so the
    // pop match vector is at most one-hot.
    assign push_accept = bus.push_i && alloc_valid && !(|push_match);
    assign pop_do      = bus.pop_i && (|pop_match);
    assign pop_idx     = IDX_W'(onehot_to_bin(VEC_W_MAX'(pop_match)));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid && (entry_q[i].age != AGE_MAX)) begin
                entry_d[i].age = entry_q[i].age + AGE_W_MAX'(1);
            end
            // A retired slot returns to all-zero, so a free entry holds age 0.
            if (pop_do && (pop_idx == IDX_W'(i))) entry_d[i] = '0;
            // The allocator only picks slots that were free before the edge,
            // so a slot freed by a same-cycle pop is never reused here.
            if (push_accept && alloc_oh[i]) begin
                entry_d[i] = '{valid: 1'b1,
                               id:    ID_W_MAX'(bus.push_ID_i),
                               addr:  ADDR_W_MAX'(bus.push_addr_i),
                               age:   '0};
            end
        end

        unique case ({push_accept, pop_do})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The flag and index stay frozen while set. A clear overrides a
        // coincident set, and the flag re-arms on the next cycle.
        timeout_d = timeout_q;
        tidx_d    = tidx_q;
        if (bus.timeout_clr_i) begin
            timeout_d = 1'b0;
        end else if (!timeout_q && (|at_max)) begin
            timeout_d = 1'b1;
            tidx_d    = IDX_W'(lowest_set_idx(VEC_W_MAX'(at_max)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: the entry table is reset as well, because in-flight refills must be forgotten on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            tidx_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
            count_q   <= count_d;
            timeout_q <= timeout_d;
            tidx_q    <= tidx_d;
        end
    end

    assign bus.push_full_o           = !alloc_valid;
    assign bus.push_error_o          = bus.push_i && !push_accept;
    assign bus.pop_empty_o           = !(|valid_vec);
    assign bus.pop_error_o           = bus.pop_i && !(|pop_match);
    assign bus.RESP_check_is_valid_o = bus.RESP_check_req_i && (|chk_match);
    assign bus.lookup_hit_o          = |look_match;
    assign bus.count_o               = count_q;
    assign bus.timeout_o             = timeout_q;
    assign bus.timeout_idx_o         = tidx_q;
endmodule

// File: tb/tb_refill_tracker_param.sv
// -----------------------------------------------------------------------------
// tb_refill_tracker_param
// Directed bench for refill_tracker_param with DEPTH=4 and TO_WIDTH=4.
// Inputs change 1 ns after the rising edge. Combinational outputs are
// sampled 2 ns later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_refill_tracker_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    refill_tracker_if #(.DEPTH(4), .ID_WIDTH(14), .ADDR_WIDTH(28)) bus ();

    refill_tracker_param #(.DEPTH(4), .ID_WIDTH(14), .ADDR_WIDTH(28), .TO_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.push_i = 1'b0; bus.push_ID_i = '0; bus.push_addr_i = '0;
        bus.pop_i = 1'b0; bus.pop_ID_i = '0;
        bus.RESP_check_req_i = 1'b0; bus.RESP_check_ID_i = '0;
        bus.lookup_addr_i = '0; bus.timeout_clr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        if (bus.push_full_o !== 1'b0) begin $display("FAIL reset_full: got %b expected 0", bus.push_full_o); n_fail++; end
        n_checks++;
        if (bus.pop_empty_o !== 1'b1) begin $display("FAIL reset_empty: got %b expected 1", bus.pop_empty_o); n_fail++; end
        n_checks++;
        if (bus.count_o !== 3'd0) begin $display("FAIL reset_count: got %0d expected 0", bus.count_o); n_fail++; end
        n_checks++;
        if ({bus.timeout_o, bus.timeout_idx_o} !== 3'b000) begin
            $display("FAIL reset_timeout: got %b/%0d expected 0/0", bus.timeout_o, bus.timeout_idx_o); n_fail++;
        end
        n_checks++;
        if ({bus.push_error_o, bus.pop_error_o, bus.lookup_hit_o, bus.RESP_check_is_valid_o} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.push_error_o, bus.pop_error_o, bus.lookup_hit_o, bus.RESP_check_is_valid_o}); n_fail++;
        end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Scenario 1: fill all four entries, then overflow.
    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            bus.push_i = 1'b1;
            bus.push_ID_i = 14'(8'h11 * (k + 1));
            bus.push_addr_i = 28'(32'h1000 + k);
            #2;
            if (bus.push_error_o !== 1'b0) begin $display("FAIL fill_err%0d: got %b expected 0", k, bus.push_error_o); n_fail++; end
            n_checks++;
            step();
        end
        clear_inputs();
        #2;
        if (bus.count_o !== 3'd4) begin $display("FAIL fill_count: got %0d expected 4", bus.count_o); n_fail++; end
        n_checks++;
        if (bus.push_full_o !== 1'b1) begin $display("FAIL fill_full: got %b expected 1", bus.push_full_o); n_fail++; end
        n_checks++;
        bus.RESP_check_req_i = 1'b1; bus.RESP_check_ID_i = 14'h33;
        #1;
        if (bus.RESP_check_is_valid_o !== 1'b1) begin $display("FAIL fill_chk33: got %b expected 1", bus.RESP_check_is_valid_o); n_fail++; end
        n_checks++;
        bus.RESP_check_req_i = 1'b0;
        #1;
        if (bus.RESP_check_is_valid_o !== 1'b0) begin $display("FAIL fill_chk_noreq: got %b expected 0", bus.RESP_check_is_valid_o); n_fail++; end
        n_checks++;
        bus.push_i = 1'b1; bus.push_ID_i = 14'h99;
        #1;
        if (bus.push_error_o !== 1'b1) begin $display("FAIL overflow_err: got %b expected 1", bus.push_error_o); n_fail++; end
        n_checks++;
        step();
        clear_inputs();
        #2;
        if (bus.count_o !== 3'd4) begin $display("FAIL overflow_count: got %0d expected 4", bus.count_o); n_fail++; end
        n_checks++;
    endtask

    // Scenario 2: pop+push while full, then reuse of entry 1.
    task automatic test_push_pop_full();
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h22;
        bus.push_i = 1'b1; bus.push_ID_i = 14'h55; bus.push_addr_i = 28'h5555;
        #2;
        if (bus.push_error_o !== 1'b1) begin $display("FAIL pp_push_err: got %b expected 1", bus.push_error_o); n_fail++; end
        n_checks++;
        if (bus.pop_error_o !== 1'b0) begin $display("FAIL pp_pop_err: got %b expected 0", bus.pop_error_o); n_fail++; end
        n_checks++;
        step();
        clear_inputs();
        bus.RESP_check_req_i = 1'b1; bus.RESP_check_ID_i = 14'h22;
        #2;
        if ({bus.count_o, bus.push_full_o, bus.RESP_check_is_valid_o} !== {3'd3, 1'b0, 1'b0}) begin
            $display("FAIL pp_after: got count=%0d full=%b chk=%b expected 3/0/0",
                     bus.count_o, bus.push_full_o, bus.RESP_check_is_valid_o); n_fail++;
        end
        n_checks++;
        clear_inputs();
        bus.push_i = 1'b1; bus.push_ID_i = 14'h55; bus.push_addr_i = 28'h5555;
        step();
        clear_inputs();
        #2;
        if ({bus.count_o, bus.push_full_o} !== {3'd4, 1'b1}) begin
            $display("FAIL pp_refill: got count=%0d full=%b expected 4/1", bus.count_o, bus.push_full_o); n_fail++;
        end
        n_checks++;
        // Keep only 0x55, then push 0x66 into entry 0. 0x55 is older, so the
        // timeout index must name its slot, which is entry 1.
        for (int k = 0; k < 3; k++) begin
            bus.pop_i = 1'b1;
            bus.pop_ID_i = (k == 0) ? 14'h11 : (k == 1) ? 14'h33 : 14'h44;
            step();
        end
        clear_inputs();
        bus.push_i = 1'b1; bus.push_ID_i = 14'h66; bus.timeout_clr_i = 1'b1;
        step();
        clear_inputs();
        for (int c = 0; c < 40 && !bus.timeout_o; c++) step();
        #1;
        if (bus.timeout_o !== 1'b1) begin $display("FAIL pp_timeout_wait: got %b expected 1", bus.timeout_o); n_fail++; end
        n_checks++;
        if (bus.timeout_idx_o !== 2'd1) begin $display("FAIL pp_entry1: got idx %0d expected 1", bus.timeout_idx_o); n_fail++; end
        n_checks++;
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h55; step();
        bus.pop_ID_i = 14'h66; bus.timeout_clr_i = 1'b1; step();
        clear_inputs();
        bus.timeout_clr_i = 1'b1; step();
        clear_inputs();
        #2;
        if ({bus.count_o, bus.pop_empty_o, bus.timeout_o} !== {3'd0, 1'b1, 1'b0}) begin
            $display("FAIL pp_drain: got count=%0d empty=%b to=%b expected 0/1/0",
                     bus.count_o, bus.pop_empty_o, bus.timeout_o); n_fail++;
        end
        n_checks++;
    endtask

    // Scenario 3: duplicate ID rejection, line lookup, same-cycle visibility.
    task automatic test_dup_lookup();
        bus.push_i = 1'b1; bus.push_ID_i = 14'h11; bus.push_addr_i = 28'h100;
        step();
        bus.push_addr_i = 28'h200;
        bus.lookup_addr_i = 28'h100;
        #2;
        if (bus.push_error_o !== 1'b1) begin $display("FAIL dup_err: got %b expected 1", bus.push_error_o); n_fail++; end
        n_checks++;
        if (bus.lookup_hit_o !== 1'b1) begin $display("FAIL lookup_hit: got %b expected 1", bus.lookup_hit_o); n_fail++; end
        n_checks++;
        step();
        clear_inputs();
        bus.lookup_addr_i = 28'h200;
        #2;
        if ({bus.count_o, bus.lookup_hit_o} !== {3'd1, 1'b0}) begin
            $display("FAIL dup_nochange: got count=%0d hit=%b expected 1/0", bus.count_o, bus.lookup_hit_o); n_fail++;
        end
        n_checks++;
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h11;
        step();
        clear_inputs();
        bus.lookup_addr_i = 28'h100;
        #2;
        if (bus.lookup_hit_o !== 1'b0) begin $display("FAIL lookup_after_pop: got %b expected 0", bus.lookup_hit_o); n_fail++; end
        n_checks++;
        // A same-cycle push is invisible to lookup.
        bus.push_i = 1'b1; bus.push_ID_i = 14'h22; bus.push_addr_i = 28'h300; bus.lookup_addr_i = 28'h300;
        #1;
        if (bus.lookup_hit_o !== 1'b0) begin $display("FAIL lookup_same_cycle: got %b expected 0", bus.lookup_hit_o); n_fail++; end
        n_checks++;
        step();
        bus.push_i = 1'b0;
        #1;
        if (bus.lookup_hit_o !== 1'b1) begin $display("FAIL lookup_next_cycle: got %b expected 1", bus.lookup_hit_o); n_fail++; end
        n_checks++;
        // When pop and push carry the same ID, the old entry retires and the push is rejected.
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h22; bus.push_i = 1'b1; bus.push_ID_i = 14'h22;
        #1;
        if (bus.push_error_o !== 1'b1) begin $display("FAIL same_id_err: got %b expected 1", bus.push_error_o); n_fail++; end
        n_checks++;
        step();
        clear_inputs();
        bus.RESP_check_req_i = 1'b1; bus.RESP_check_ID_i = 14'h22;
        #2;
        if ({bus.count_o, bus.RESP_check_is_valid_o} !== {3'd0, 1'b0}) begin
            $display("FAIL same_id_after: got count=%0d chk=%b expected 0/0", bus.count_o, bus.RESP_check_is_valid_o); n_fail++;
        end
        n_checks++;
        clear_inputs();
    endtask

    // Scenario 4: pop on an empty table.
    task automatic test_empty_pop();
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h7F;
        bus.RESP_check_req_i = 1'b1; bus.RESP_check_ID_i = 14'h7F;
        #2;
        if ({bus.pop_error_o, bus.pop_empty_o, bus.RESP_check_is_valid_o} !== 3'b110) begin
            $display("FAIL empty_pop: got err=%b empty=%b chk=%b expected 1/1/0",
                     bus.pop_error_o, bus.pop_empty_o, bus.RESP_check_is_valid_o); n_fail++;
        end
        n_checks++;
        step();
        bus.pop_i = 1'b0;
        #2;
        if ({bus.count_o, bus.pop_error_o} !== {3'd0, 1'b0}) begin
            $display("FAIL empty_pop_after: got count=%0d err=%b expected 0/0", bus.count_o, bus.pop_error_o); n_fail++;
        end
        n_checks++;
        clear_inputs();
    endtask

    // Scenario 5: watchdog timing, sticky clear and re-arm.
    task automatic test_timeout();
        bus.push_i = 1'b1; bus.push_ID_i = 14'h11; bus.push_addr_i = 28'h100;
        step();
        clear_inputs();
        for (int c = 0; c < 15; c++) step();
        #1;
        if (bus.timeout_o !== 1'b0) begin $display("FAIL to_early: got %b expected 0", bus.timeout_o); n_fail++; end
        n_checks++;
        step();
        #1;
        if ({bus.timeout_o, bus.timeout_idx_o} !== {1'b1, 2'd0}) begin
            $display("FAIL to_set: got %b/%0d expected 1/0", bus.timeout_o, bus.timeout_idx_o); n_fail++;
        end
        n_checks++;
        bus.timeout_clr_i = 1'b1;
        step();
        bus.timeout_clr_i = 1'b0;
        #1;
        if (bus.timeout_o !== 1'b0) begin $display("FAIL to_clear: got %b expected 0", bus.timeout_o); n_fail++; end
        n_checks++;
        step();
        #1;
        if (bus.timeout_o !== 1'b1) begin $display("FAIL to_rearm: got %b expected 1", bus.timeout_o); n_fail++; end
        n_checks++;
        bus.pop_i = 1'b1; bus.pop_ID_i = 14'h11; bus.timeout_clr_i = 1'b1;
        step();
        clear_inputs();
        step();
        #1;
        if ({bus.timeout_o, bus.count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL to_stays_clear: got to=%b count=%0d expected 0/0", bus.timeout_o, bus.count_o); n_fail++;
        end
        n_checks++;
    endtask

    // Scenario 6: asynchronous reset with live entries and the flag set.
    task automatic test_reset_mid();
        for (int k = 1; k <= 3; k++) begin
            bus.push_i = 1'b1; bus.push_ID_i = 14'(k); bus.push_addr_i = 28'(k);
            step();
        end
        clear_inputs();
        for (int c = 0; c < 40 && !bus.timeout_o; c++) step();
        #1;
        if ({bus.timeout_o, bus.count_o} !== {1'b1, 3'd3}) begin
            $display("FAIL rm_pre: got to=%b count=%0d expected 1/3", bus.timeout_o, bus.count_o); n_fail++;
        end
        n_checks++;
        #1;
        rst_n = 1'b0;
        bus.RESP_check_req_i = 1'b1; bus.RESP_check_ID_i = 14'd1;
        #1;
        if ({bus.count_o, bus.pop_empty_o, bus.push_full_o, bus.timeout_o, bus.timeout_idx_o, bus.RESP_check_is_valid_o}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            $display("FAIL rm_async: got count=%0d empty=%b full=%b to=%b idx=%0d chk=%b expected 0/1/0/0/0/0",
                     bus.count_o, bus.pop_empty_o, bus.push_full_o, bus.timeout_o,
                     bus.timeout_idx_o, bus.RESP_check_is_valid_o); n_fail++;
        end
        n_checks++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.push_i = 1'b1; bus.push_ID_i = 14'h9;
        step();
        clear_inputs();
        for (int c = 0; c < 40 && !bus.timeout_o; c++) step();
        #1;
        if ({bus.timeout_o, bus.timeout_idx_o, bus.count_o} !== {1'b1, 2'd0, 3'd1}) begin
            $display("FAIL rm_realloc: got to=%b idx=%0d count=%0d expected 1/0/1",
                     bus.timeout_o, bus.timeout_idx_o, bus.count_o); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_fill();
        test_push_pop_full();
        test_dup_lookup();
        test_empty_pop();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
